// File: rtl/max7219_chain_funcmod_if.sv
// Handshake and operand bundle between the display control FSM (master)
// and the MAX7219 chain write engine (slave).
interface max7219_chain_funcmod_if #(
  parameter int NDEV = 4
);
  logic                iCall;
  logic [4*NDEV-1:0]   iADDR;
  logic [8*NDEV-1:0]   iDATA;
  logic                oDone;
  logic                oBusy;

  modport master (output iCall, iADDR, iDATA, input  oDone, oBusy);
  modport slave  (input  iCall, iADDR, iDATA, output oDone, oBusy);
endinterface

// File: rtl/max7219_chain_funcmod.sv
// Serial write engine for a daisy-chain of NDEV MAX7219 drivers on one
// CS/SCLK/DATA bus. One call shifts one 16-bit frame per device, farthest
// device first, then raises CS so every device latches together.
// Optional feature macro: MAX7219_AUTOINIT_EN (power-up init sequence).
module max7219_chain_funcmod #(
  parameter int NDEV    = 4,
  parameter int FCLK    = 25,
  parameter int FHALF   = 12,
  parameter int CS_HOLD = 4
`ifdef MAX7219_AUTOINIT_EN
  , parameter logic [3:0] INTENSITY = 4'h8
`endif
) (
  input  logic                    CLOCK,
  input  logic                    RST_n,
  max7219_chain_funcmod_if.slave  bus,
  output logic                    MAX7219_CS,
  output logic                    MAX7219_SCLK,
  output logic                    MAX7219_DATA
);

  localparam int NBITS = 16 * NDEV;
  localparam int BW    = $clog2(NBITS + 1);
  localparam int DW    = $clog2(FCLK);
  localparam int HW    = $clog2(CS_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_CSHI, S_DONE, S_INIT
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [DW-1:0]    div_q,   div_d;
  logic [HW-1:0]    hold_q,  hold_d;
`ifdef MAX7219_AUTOINIT_EN
  logic [2:0]       init_q,  init_d;
  logic             init_act_q, init_act_d;

  // Broadcast init frame for a given step, replicated to every device.
  function automatic logic [NBITS-1:0] init_frame(input logic [2:0] idx);
    logic [15:0] f;
    case (idx)
      3'd0:    f = 16'h0C01;            // shutdown off
      3'd1:    f = 16'h0B07;            // scan all digits
      3'd2:    f = 16'h0900;            // no decode
      3'd3:    f = {12'h0A0, INTENSITY};
      default: f = 16'h0F00;            // display test off
    endcase
    return {NDEV{f}};
  endfunction
`endif

  // Device k occupies bits [16k+15:16k]; device NDEV-1 leaves first.
  function automatic logic [NBITS-1:0] pack_frames(input logic [4*NDEV-1:0] a,
                                                   input logic [8*NDEV-1:0] d);
    logic [NBITS-1:0] r;
    for (int k = 0; k < NDEV; k++) r[16*k +: 16] = {4'b0000, a[4*k +: 4], d[8*k +: 8]};
    return r;
  endfunction

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
`ifdef MAX7219_AUTOINIT_EN
      state_q    <= S_INIT;
      init_q     <= '0;
      init_act_q <= 1'b1;
`else
      state_q    <= S_IDLE;
`endif
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      hold_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
`ifdef MAX7219_AUTOINIT_EN
      init_q     <= init_d;
      init_act_q <= init_act_d;
`endif
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    // NOTE: hold-value defaults first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    hold_d  = hold_q;
`ifdef MAX7219_AUTOINIT_EN
    init_d     = init_q;
    init_act_d = init_act_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.iCall) begin
          shift_d = pack_frames(bus.iADDR, bus.iDATA);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DW'(FCLK - 1)) begin
          // Bit boundary: next bit appears at count 0 while SCLK is low.
          div_d   = '0;
          shift_d = {shift_q[NBITS-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BW'(NBITS - 1)) begin
            hold_d  = '0;
            state_d = S_CSHI;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_CSHI: begin
        if (hold_q == HW'(CS_HOLD - 1)) begin
`ifdef MAX7219_AUTOINIT_EN
          if (init_act_q) begin
            if (init_q == 3'd4) begin
              init_act_d = 1'b0;
              state_d    = S_IDLE;
            end else begin
              init_d  = init_q + 1'b1;
              state_d = S_INIT;
            end
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_INIT: begin
`ifdef MAX7219_AUTOINIT_EN
        shift_d = init_frame(init_q);
        state_d = S_LOAD;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin and handshake outputs decoded from the current state.
  always_comb begin
    MAX7219_CS   = 1'b1;
    MAX7219_SCLK = 1'b0;
    MAX7219_DATA = 1'b0;
    bus.oDone    = 1'b0;
    bus.oBusy    = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD: begin
        MAX7219_CS   = 1'b0;
        MAX7219_DATA = shift_q[NBITS-1];
      end
      S_SHIFT: begin
        MAX7219_CS   = 1'b0;
        MAX7219_DATA = shift_q[NBITS-1];
        MAX7219_SCLK = (div_q >= DW'(FHALF));
      end
      S_DONE:  bus.oDone = 1'b1;
      default: ;
    endcase
  end

endmodule
